// File: rtl/router_ingress.sv
// Packet ingress for the 1x3 router: decodes the header byte and steers header, payload and parity into one of three FIFOs.
// Latency: header written one cycle after acceptance (more if the target FIFO is full); payload and parity pass through combinationally.
// Backpressure: busy holds the source while the selected FIFO is full and during header replay and parity check; unused addr 3 is drained.
module router_ingress #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [2:0]            fifo_full,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            write_enb,
    output logic                  lfd_state,
    output logic                  parity_done,
    output logic                  err
);

    localparam int LEN_W = DATA_WIDTH - 2;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [1:0]       addr;
    } hdr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FULL,
        S_LOAD_FIRST,
        S_LOAD_DATA,
        S_CHECK,
        S_DROP
    } state_t;

    state_t                state_q, state_d;
    hdr_t                  hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0] par_q, par_d;
    logic [DATA_WIDTH-1:0] rx_par_q, rx_par_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  drop_done_q, drop_done_d;

    hdr_t hdr_in;
    logic sel_full;
    logic [2:0] sel_we;

    assign hdr_in = hdr_t'(data_in);

    function automatic logic full_of(input logic [2:0] ff, input logic [1:0] a);
        case (a)
            2'd0:    return ff[0];
            2'd1:    return ff[1];
            2'd2:    return ff[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] onehot_of(input logic [1:0] a);
        case (a)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign sel_full = full_of(fifo_full, hdr_q.addr);
    assign sel_we   = onehot_of(hdr_q.addr);

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        par_d       = par_q;
        rx_par_d    = rx_par_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        drop_done_d = 1'b0;
        busy        = 1'b0;
        data_out    = '0;
        write_enb   = 3'b000;
        lfd_state   = 1'b0;
        parity_done = drop_done_q;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    err_d = 1'b0;
                    if (hdr_in.addr == 2'd3) begin
                        state_d = S_DROP;
                    end else begin
                        hdr_d   = hdr_in;
                        par_d   = data_in;
                        cnt_d   = '0;
                        state_d = full_of(fifo_full, hdr_in.addr) ? S_WAIT_FULL : S_LOAD_FIRST;
                    end
                end
            end
            S_WAIT_FULL: begin
                busy = 1'b1;
                if (!sel_full) state_d = S_LOAD_FIRST;
            end
            S_LOAD_FIRST: begin
                busy      = 1'b1;
                data_out  = hdr_q;
                write_enb = sel_we;
                lfd_state = 1'b1;
                state_d   = S_LOAD_DATA;
            end
            S_LOAD_DATA: begin
                busy     = sel_full;
                data_out = data_in;
                if (!sel_full) begin
                    write_enb = sel_we;
                    if (pkt_valid) begin
                        par_d = par_q ^ data_in;
                        if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
                    end else begin
                        // pkt_valid low marks the trailing parity byte
                        rx_par_d = data_in;
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                busy        = 1'b1;
                parity_done = 1'b1;
                err_d       = (rx_par_q != par_q) || (32'(cnt_q) != 32'(hdr_q.len));
                state_d     = S_IDLE;
            end
            S_DROP: begin
                if (!pkt_valid) begin
                    drop_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (reset) begin
            busy        = 1'b0;
            data_out    = '0;
            write_enb   = 3'b000;
            lfd_state   = 1'b0;
            parity_done = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            par_q       <= '0;
            rx_par_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            drop_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            par_q       <= par_d;
            rx_par_q    <= rx_par_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            drop_done_q <= drop_done_d;
        end
    end

    assign err = err_q;

    a_we_onehot: assert property (@(posedge clock) $onehot0(write_enb));

endmodule

// File: doc/router_ingress.md
Name: router_ingress

Overview:
- Packet ingress controller for the 1x3 router.
- Sits between the source interface and the three router_fifo instances.
- Decodes the header byte and steers header, payload and parity into the selected FIFO, generating write_enb and lfd_state for it.
- Stalls the source on FIFO-full, checks the parity byte and the payload length, and flags errors.

Parameters:
- DATA_WIDTH, 8, byte width. Header layout is fixed: [DATA_WIDTH-1:2] = payload length, [1:0] = address.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  high for header and payload bytes; low for the parity byte
- data_in  in  DATA_WIDTH  source byte
- fifo_full  in  3  full flags of FIFO0..2
- busy  out  1  source must hold data_in/pkt_valid while high
- data_out  out  DATA_WIDTH  byte to the FIFOs (shared bus)
- write_enb  out  3  one-hot FIFO write strobe
- lfd_state  out  1  header-write marker, high with the header write
- parity_done  out  1  one-cycle pulse after the parity byte is written or dropped
- err  out  1  parity or length error on the last packet

Behaviour:
- Transfer rule: a byte is accepted in any cycle where busy=0 and the state consumes input (IDLE, LOAD_DATA, DROP).
- Outputs are combinational from state and inputs; err and the internal registers are registered.
- States: IDLE, WAIT_FULL, LOAD_FIRST, LOAD_DATA, CHECK, DROP.
- IDLE (busy=0, write_enb=0):
  - On pkt_valid with addr=data_in[1:0] in {0,1,2}: hdr_reg<=data_in, par_acc<=data_in, cnt<=0, err<=0.
  - Next state: WAIT_FULL if fifo_full[addr], else LOAD_FIRST.
  - On pkt_valid with addr=3: err<=0, go to DROP.
- WAIT_FULL (busy=1): leave for LOAD_FIRST when fifo_full[addr]=0.
- LOAD_FIRST (busy=1): data_out=hdr_reg, write_enb[addr]=1, lfd_state=1. Go to LOAD_DATA. Exactly one cycle.
- LOAD_DATA: busy=fifo_full[addr]; data_out=data_in.
  - If !fifo_full[addr] and pkt_valid: write_enb[addr]=1, par_acc<=par_acc^data_in, cnt<=cnt+1.
  - If !fifo_full[addr] and !pkt_valid: the byte is the parity byte. write_enb[addr]=1, rx_par<=data_in, go to CHECK.
  - If fifo_full[addr]: write_enb=0, nothing is accepted, state holds. A full flag going high and low mid-packet needs no extra states.
- CHECK (busy=1, write_enb=0):
  - err<=(rx_par!=par_acc) || (cnt!=hdr_reg[DATA_WIDTH-1:2]).
  - parity_done=1. Go to IDLE.
- DROP (busy=0, write_enb=0): consume bytes while pkt_valid=1. The first byte with pkt_valid=0 is consumed as parity, then parity_done=1 and go to IDLE.
- cnt is 6 bits and saturates at 63; no wrap. Header length 0 is legal: the parity byte follows the header directly.
- A packet with more payload bytes than its header length is still written in full, and err is set in CHECK.
- data_out=0 in all states other than LOAD_FIRST and LOAD_DATA.
- err holds its value until the next header is accepted or reset.
- Reset (any state, any cycle): state<=IDLE; hdr_reg, par_acc, rx_par, cnt, err <=0.
  - During reset: busy=0, write_enb=0, lfd_state=0, parity_done=0, data_out=0.
  - Bytes already written to a FIFO are not retracted.
- Only one FIFO is ever written per cycle. fifo_full of non-selected FIFOs is ignored.

Test Plan:
- Reset, then header 8'h39 (len 14, addr 1), 14 random payload bytes, correct parity → write_enb=3'b010 for 16 cycles. lfd_state high only on the first write, with data_out=8'h39. parity_done pulses one cycle later; err=0.
- Same packet with parity XOR 8'h01 → all 16 bytes written, err=1 from the cycle after CHECK until the next header; parity_done pulses.
- Header 8'h0A (len 2, addr 2) with fifo_full=3'b100 for 5 cycles → busy=1, write_enb=0 throughout. Header written in the cycle after fifo_full[2] drops; then normal completion.
- Header 8'h20 (len 8, addr 0); fifo_full[0]=1 for 3 cycles after payload byte 3 → busy=1 and no writes during the stall; byte 4 written when full clears; final cnt=8, err=0.
- Header 8'h13 (addr 3), 4 payload bytes, parity → write_enb stays 0, busy stays 0; parity_done pulses after the parity byte; state returns to IDLE.
- Header 8'h11 (len 4, addr 1), only 2 payload bytes, then parity → err=1 (length mismatch). Separately, reset asserted mid-payload → next cycle busy=0, write_enb=0, err=0, state IDLE; the next packet is handled normally.
